// File: rtl/fir_coef_ctrl_if.sv
// Coefficient-load handshake between a configuration master and the
// FIR coefficient controller. One word per cycle with cfg_valid & cfg_ready.
interface fir_coef_ctrl_if #(
  parameter int TAP_WIDTH = 32
);
  logic                        cfg_start;
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic signed [TAP_WIDTH-1:0] cfg_data;
  logic                        cfg_last;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient controller for the FIR datapath: serial load into a
// shadow bank, swap to the active bank on a sample boundary, then mask the
// FIR output-valid flag while the MAC pipeline drains stale products.

// One tap slot: shadow word written during load, active word updated on swap.
module fir_coef_tap #(
  parameter int TAP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [TAP_WIDTH-1:0] wr_data,
  input  logic                 swap,
  output logic [TAP_WIDTH-1:0] active
);
  logic [TAP_WIDTH-1:0] shadow;

  // Shadow capture and shadow->active transfer; never both in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (swap)  active <= shadow;
    end
  end
endmodule

module fir_coef_ctrl #(
  parameter int TAP_WIDTH    = 32,
  parameter int TAP_COUNT    = 34,
  parameter int IDX_WIDTH    = 6,
  parameter int FLUSH_CYCLES = 36
) (
  input  logic                           clk,
  input  logic                           reset_n,
  fir_coef_ctrl_if.slave                 cfg,
  input  logic                           sample_strobe,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_active,
  output logic                           fir_out_valid,
  output logic                           busy,
  output logic                           load_done,
  output logic                           load_err
);
  // Counter sized to hold FLUSH_CYCLES-1 even for FLUSH_CYCLES = 1.
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(TAP_COUNT - 1);
  localparam logic [CNT_W-1:0]     FLUSH_TOP = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_WIDTH-1:0] idx, idx_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 err_nxt;
  logic                 done_nxt;
  // Marks a flush started by reset so its completion stays silent.
  logic                 rst_flush, rst_flush_nxt;
  logic                 swap;
  logic                 beat;

  assign beat          = cfg.cfg_valid && (state == LOAD);
  assign cfg.cfg_ready = (state == LOAD);
  assign fir_out_valid = (state != FLUSH);
  assign busy          = (state != IDLE);

  // State and bookkeeping registers; reset lands in a full-length flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FLUSH;
      idx       <= '0;
      cnt       <= FLUSH_TOP;
      load_err  <= 1'b0;
      load_done <= 1'b0;
      rst_flush <= 1'b1;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      load_err  <= err_nxt;
      load_done <= done_nxt;
      rst_flush <= rst_flush_nxt;
    end
  end

  // Next-state logic: load sequencing, error detection, swap and flush count.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    err_nxt       = load_err;
    done_nxt      = 1'b0;
    rst_flush_nxt = rst_flush;
    swap          = 1'b0;
    case (state)
      IDLE: begin
        if (cfg.cfg_start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      LOAD: begin
        if (beat) begin
          if (idx == LAST_IDX) begin
            if (cfg.cfg_last) begin
              state_nxt = WAIT_SWAP;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else if (cfg.cfg_last) begin
            // Short load: shadow is partially overwritten and never swapped.
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_WIDTH'(1);
          end
        end
      end
      WAIT_SWAP: begin
        if (sample_strobe) begin
          swap          = 1'b1;
          cnt_nxt       = FLUSH_TOP;
          rst_flush_nxt = 1'b0;
          state_nxt     = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt     = IDLE;
          done_nxt      = !rst_flush;
          rst_flush_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One storage slot per tap; the write enable decodes the load index.
  for (genvar k = 0; k < TAP_COUNT; k++) begin : g_tap
    fir_coef_tap #(.TAP_WIDTH(TAP_WIDTH)) u_tap (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (beat && (idx == IDX_WIDTH'(k))),
      .wr_data (cfg.cfg_data),
      .swap    (swap),
      .active  (taps_active[k*TAP_WIDTH +: TAP_WIDTH])
    );
  end
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: reset flush, clean loads with and
// without stalls, short/unterminated loads, reset during swap wait and flush.
module tb_fir_coef_ctrl;
  localparam int TW = 32;
  localparam int TC = 34;
  localparam int FC = 36;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sample_strobe;
  logic [TC*TW-1:0]  taps_active;
  logic              fir_out_valid, busy, load_done, load_err;

  int n_chk = 0;
  int n_err = 0;
  logic [TW-1:0] exp_taps [TC];

  fir_coef_ctrl_if #(.TAP_WIDTH(TW)) cfg ();

  fir_coef_ctrl #(
    .TAP_WIDTH(TW), .TAP_COUNT(TC), .IDX_WIDTH(6), .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg           (cfg),
    .sample_strobe (sample_strobe),
    .taps_active   (taps_active),
    .fir_out_valid (fir_out_valid),
    .busy          (busy),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Coefficient patterns: ascending, negated (sign bits exercised), marker.
  function automatic logic [TW-1:0] pat(input int mode, input int k);
    case (mode)
      0:       return TW'(k + 1);
      1:       return TW'(-(k + 1));
      default: return 32'hA5A5_0000 ^ TW'(k);
    endcase
  endfunction

  task automatic set_exp(input int mode);
    for (int k = 0; k < TC; k++) exp_taps[k] = (mode < 0) ? '0 : pat(mode, k);
  endtask

  task automatic check_taps(input string tag);
    for (int k = 0; k < TC; k++)
      chk($sformatf("%s_tap%0d", tag, k), 64'(taps_active[k*TW +: TW]), 64'(exp_taps[k]));
  endtask

  // Counts cycles until fir_out_valid rises and load_done pulses seen.
  task automatic wait_flush(input string tag, input int exp_pulses);
    int n = 0;
    int p = 0;
    chk({tag, "_fov_lo"}, 64'(fir_out_valid), 64'd0);
    while (!fir_out_valid && n < 200) begin
      step();
      n++;
      if (load_done) p++;
    end
    chk({tag, "_flush_len"}, 64'(n), 64'(FC));
    chk({tag, "_done_pulses"}, 64'(p), 64'(exp_pulses));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    step();
    chk({tag, "_done_off"}, 64'(load_done), 64'd0);
  endtask

  // Issues cfg_start (with a bogus valid word that must not be taken), then
  // offers nb words. last_at = 1-based beat carrying cfg_last (0 = never).
  task automatic send_load(input int mode, input int nb, input int last_at,
                           input bit toggle, input int gap_at, input bit strobe_last,
                           output int beats);
    int  k = 0;
    int  cyc = 0;
    int  gap = 5;
    bit  ph = 1'b1;
    bit  v;
    beats = 0;
    cfg.cfg_start = 1'b1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 32'hDEAD_BEEF;
    cfg.cfg_last  = 1'b0;
    chk("start_rdy", 64'(cfg.cfg_ready), 64'd0);
    step();
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    chk("start_clr_err", 64'(load_err), 64'd0);
    chk("load_rdy", 64'(cfg.cfg_ready), 64'd1);
    while (k < nb && cyc < 400) begin
      v  = toggle ? ph : 1'b1;
      ph = !ph;
      if (k == gap_at && gap > 0) begin
        v = 1'b0;
        gap--;
      end
      cfg.cfg_valid = v;
      cfg.cfg_data  = pat(mode, k);
      cfg.cfg_last  = (k + 1 == last_at);
      sample_strobe = strobe_last && v && (k + 1 == nb);
      if (v && cfg.cfg_ready) begin
        k++;
        beats++;
      end
      step();
      cyc++;
    end
    cfg.cfg_valid = 1'b0;
    cfg.cfg_last  = 1'b0;
    sample_strobe = 1'b0;
    chk("load_in_time", 64'(cyc < 400), 64'd1);
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
  endtask

  int b;

  initial begin
    reset_n       = 1'b0;
    sample_strobe = 1'b0;
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    cfg.cfg_last  = 1'b0;

    // 1: reset held 3 cycles, then a silent 36-cycle flush
    repeat (3) step();
    set_exp(-1);
    chk("rst_fov", 64'(fir_out_valid), 64'd0);
    chk("rst_rdy", 64'(cfg.cfg_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    reset_n = 1'b1;
    check_taps("rst");
    wait_flush("rst", 0);

    // 2: clean load of k+1, swap on strobe, flush with one done pulse
    send_load(0, TC, TC, 1'b0, -1, 1'b0, b);
    chk("s2_beats", 64'(b), 64'(TC));
    chk("s2_wait_busy", 64'(busy), 64'd1);
    chk("s2_wait_rdy", 64'(cfg.cfg_ready), 64'd0);
    chk("s2_wait_fov", 64'(fir_out_valid), 64'd1);
    repeat (3) step();
    check_taps("s2_preswap");
    strobe();
    set_exp(0);
    check_taps("s2");
    wait_flush("s2", 1);

    // negated bank so the next load's swap is visible
    send_load(1, TC, TC, 1'b0, -1, 1'b0, b);
    strobe();
    set_exp(1);
    check_taps("neg");
    wait_flush("neg", 1);

    // 3: valid toggling plus a 5-cycle gap; strobe on the final beat is too early
    send_load(0, TC, TC, 1'b1, 7, 1'b1, b);
    chk("s3_beats", 64'(b), 64'(TC));
    chk("s3_wait_busy", 64'(busy), 64'd1);
    check_taps("s3_noswap");
    strobe();
    set_exp(0);
    check_taps("s3");
    wait_flush("s3", 1);

    // 4: short load (cfg_last on beat 10)
    send_load(2, 10, 10, 1'b0, -1, 1'b0, b);
    chk("s4_beats", 64'(b), 64'd10);
    chk("s4_err", 64'(load_err), 64'd1);
    chk("s4_busy", 64'(busy), 64'd0);
    chk("s4_fov", 64'(fir_out_valid), 64'd1);
    strobe();
    chk("s4_fov_post", 64'(fir_out_valid), 64'd1);
    check_taps("s4");

    // 5: 34 beats without cfg_last; start clears the old error first
    send_load(2, TC, 0, 1'b0, -1, 1'b0, b);
    chk("s5_beats", 64'(b), 64'(TC));
    chk("s5_err", 64'(load_err), 64'd1);
    chk("s5_busy", 64'(busy), 64'd0);
    strobe();
    chk("s5_fov", 64'(fir_out_valid), 64'd1);
    chk("s5_busy_post", 64'(busy), 64'd0);
    check_taps("s5");

    // 6a: reset during WAIT_SWAP, with strobe and start asserted under reset
    send_load(1, TC, TC, 1'b0, -1, 1'b0, b);
    chk("s6a_busy", 64'(busy), 64'd1);
    reset_n       = 1'b0;
    cfg.cfg_start = 1'b1;
    sample_strobe = 1'b1;
    repeat (2) step();
    set_exp(-1);
    check_taps("s6a_rst");
    chk("s6a_fov", 64'(fir_out_valid), 64'd0);
    chk("s6a_busy_rst", 64'(busy), 64'd1);
    reset_n       = 1'b1;
    cfg.cfg_start = 1'b0;
    sample_strobe = 1'b0;
    wait_flush("s6a", 0);
    check_taps("s6a");

    // 6b: start and strobe mid-flush are ignored, then reset restarts the flush
    send_load(2, TC, TC, 1'b0, -1, 1'b0, b);
    strobe();
    set_exp(2);
    check_taps("s6b_swap");
    repeat (5) step();
    cfg.cfg_start = 1'b1;
    sample_strobe = 1'b1;
    step();
    cfg.cfg_start = 1'b0;
    sample_strobe = 1'b0;
    repeat (4) step();
    chk("s6b_fov", 64'(fir_out_valid), 64'd0);
    chk("s6b_busy", 64'(busy), 64'd1);
    chk("s6b_rdy", 64'(cfg.cfg_ready), 64'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set_exp(-1);
    check_taps("s6b_rst");
    wait_flush("s6b", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
